if_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register: it owns the PC/nPC pair (delay-slot semantics), issues word fetches to instruction memory over a req/ack handshake, and presents `instruction_in`/`PC` to IF/ID each cycle. It inserts a NOP (32'h0) whenever no fetched word is ready. It also holds on the hazard-unit load enable `LE` and applies branch/jump redirects from ID.

---
 rtl/if_fetch_unit.sv | 127 ++++++++++++
 tb/tb_if_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Purpose  : Instruction-fetch stage feeding the IF/ID pipeline register.
//             Owns the PC/nPC pair with delay-slot semantics. Fetches one
//             word at a time from instruction memory over a req/ack
//             handshake. Presents a NOP whenever no fetched word is ready.
//             Holds on the hazard-unit load enable and applies branch/jump
//             redirects from ID, remembering a redirect that arrives while
//             the stage cannot advance.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC        PC loaded on reset (nPC loads RESET_PC+4)
//    NOP_WORD        word presented when no valid fetch is available
//  Ports
//    clk             in   1   rising-edge clock
//    reset           in   1   synchronous, active-high
//    LE              in   1   advance enable (1 = consume presented word)
//    branch_taken    in   1   branch/jump in ID is taken
//    ID_TA           in  32   branch/jump target (low two bits ignored)
//    imem_req        out  1   fetch request
//    imem_addr       out 32   fetch address (always PC)
//    imem_ack        in   1   read data valid (only honoured while requesting)
//    imem_rdata      in  32   fetched instruction word
//    instruction_out out 32   word to IF/ID instruction_in
//    pc_out          out 32   PC of instruction_out, to IF/ID PC
//    fetch_valid     out  1   instruction_out is a real fetched word
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LE,
  input  logic        branch_taken,
  input  logic [31:0] ID_TA,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        fetch_valid
);

  localparam logic [31:0] c_WORD_STEP  = 32'd4;
  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,   // first cycle of a fetch request
    S_WAIT  = 2'd1,   // request outstanding, address held stable
    S_READY = 2'd2    // fetched word held in r_ibuf, presented to IF/ID
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] r_ibuf;
  logic        r_pend;
  logic [31:0] r_pend_ta;

  logic        w_advance;
  logic [31:0] w_ta_aligned;
  logic [31:0] w_next;

  assign w_advance    = (r_state == S_READY) && LE;
  assign w_ta_aligned = ID_TA & c_ALIGN_MASK;

  // A live redirect wins over a remembered one; otherwise sequential flow.
  // The 32-bit add wraps 0xFFFF_FFFC to 0 naturally.
  assign w_next = branch_taken ? w_ta_aligned :
                  r_pend       ? r_pend_ta    :
                                 (r_npc + c_WORD_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_npc     <= RESET_PC + c_WORD_STEP;
      r_ibuf    <= 32'h0000_0000;
      r_pend    <= 1'b0;
      r_pend_ta <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_REQ, S_WAIT: begin
          if (imem_ack) begin
            r_ibuf  <= imem_rdata;
            r_state <= S_READY;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_READY: begin
          // LE low holds everything, and acks are ignored here since no
          // request is outstanding.
          if (LE) begin
            r_pc    <= r_npc;
            r_npc   <= w_next;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase

      // The advance consumes any remembered redirect (a coincident live
      // redirect has already been folded into w_next). Without an advance,
      // a newer redirect simply replaces an older one.
      if (w_advance) begin
        r_pend <= 1'b0;
      end else if (branch_taken) begin
        r_pend    <= 1'b1;
        r_pend_ta <= w_ta_aligned;
      end
    end
  end

  // Outputs decode registered state only.
  assign imem_req        = (r_state != S_READY);
  assign imem_addr       = r_pc;
  assign pc_out          = r_pc;
  assign fetch_valid     = (r_state == S_READY);
  assign instruction_out = (r_state == S_READY) ? r_ibuf : NOP_WORD;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_unit
//  Purpose  : Self-checking bench for if_fetch_unit. A vector table covers
//             sequential fetch, memory wait, LE hold and a taken branch;
//             hand-written sequences cover pending redirects, reset during
//             an outstanding fetch and PC wrap-around; a random phase is
//             checked against a two-phase behavioural model (waiting for a
//             word / holding a word).
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] c_NOP      = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        LE;
  logic        branch_taken;
  logic [31:0] ID_TA;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        fetch_valid;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit #(
    .RESET_PC (c_RESET_PC),
    .NOP_WORD (c_NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .LE              (LE),
    .branch_taken    (branch_taken),
    .ID_TA           (ID_TA),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .fetch_valid     (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The stage is either waiting for a word or holding one.
  logic [31:0] m_pc, m_npc, m_pend_ta, m_word;
  logic        m_pend, m_have;

  task automatic model_step();
    logic [31:0] nxt;
    logic        adv;
    if (reset) begin
      m_pc = c_RESET_PC; m_npc = c_RESET_PC + 32'd4;
      m_pend = 1'b0; m_pend_ta = 32'd0; m_have = 1'b0; m_word = 32'd0;
    end else begin
      adv = m_have && LE;
      if (!m_have) begin
        if (imem_ack) begin
          m_have = 1'b1;
          m_word = imem_rdata;
        end
      end else if (LE) begin
        if (branch_taken) nxt = {ID_TA[31:2], 2'b00};
        else if (m_pend)  nxt = m_pend_ta;
        else              nxt = m_npc + 32'd4;
        m_pc   = m_npc;
        m_npc  = nxt;
        m_pend = 1'b0;
        m_have = 1'b0;
      end
      if (branch_taken && !adv) begin
        m_pend    = 1'b1;
        m_pend_ta = {ID_TA[31:2], 2'b00};
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " imem_req"},    {31'd0, imem_req},    {31'd0, !m_have});
    chk({tag, " imem_addr"},   imem_addr,            m_pc);
    chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, m_have});
    chk({tag, " instr"},       instruction_out,      m_have ? m_word : c_NOP);
    chk({tag, " pc_out"},      pc_out,               m_pc);
  endtask

  // Drive inputs away from the active edge, clock once, advance the model,
  // and leave the caller 1 time unit after the edge for sampling.
  task automatic cyc(input logic rst, input logic le, input logic bt,
                     input logic [31:0] ta, input logic ack, input logic [31:0] rd);
    @(negedge clk);
    reset = rst; LE = le; branch_taken = bt; ID_TA = ta;
    imem_ack = ack; imem_rdata = rd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic mcyc(input string tag, input logic rst, input logic le, input logic bt,
                      input logic [31:0] ta, input logic ack, input logic [31:0] rd);
    cyc(rst, le, bt, ta, ack, rd);
    check_model(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, le, bt;
    logic [31:0] ta;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
  } vec_t;

  localparam int c_NVEC = 17;
  vec_t tbl [c_NVEC];

  function automatic vec_t mk(logic rst, logic le, logic bt, logic [31:0] ta,
                              logic ack, logic [31:0] rd, logic e_req,
                              logic [31:0] e_addr, logic e_vld,
                              logic [31:0] e_ins, logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.le = le; v.bt = bt; v.ta = ta; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_ins = e_ins; v.e_pc = e_pc;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; LE = 1'b0; branch_taken = 1'b0; ID_TA = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;

    //            rst le bt ta          ack rdata          req addr        vld ins            pc
    tbl[0]  = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 32'h0,     0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,      1, 32'h1111_0000,0, 32'h0,     1, 32'h1111_0000,32'h0);
    tbl[2]  = mk(0, 1, 0, 32'h0,      0, 32'h0,        1, 32'h4,     0, 32'h0,        32'h4);
    tbl[3]  = mk(0, 1, 0, 32'h0,      1, 32'h2222_0004,0, 32'h4,     1, 32'h2222_0004,32'h4);
    // LE low for five cycles in READY; stray acks must be ignored.
    tbl[4]  = mk(0, 0, 0, 32'h0,      1, 32'hDEAD_0001,0, 32'h4,     1, 32'h2222_0004,32'h4);
    tbl[5]  = mk(0, 0, 0, 32'h0,      0, 32'hDEAD_0002,0, 32'h4,     1, 32'h2222_0004,32'h4);
    tbl[6]  = mk(0, 0, 0, 32'h0,      1, 32'hDEAD_0003,0, 32'h4,     1, 32'h2222_0004,32'h4);
    tbl[7]  = mk(0, 0, 0, 32'h0,      0, 32'hDEAD_0004,0, 32'h4,     1, 32'h2222_0004,32'h4);
    tbl[8]  = mk(0, 0, 0, 32'h0,      1, 32'hDEAD_0005,0, 32'h4,     1, 32'h2222_0004,32'h4);
    // Advance from PC=4 with a taken branch to 0x103: delay slot 8 first.
    tbl[9]  = mk(0, 1, 1, 32'h103,    0, 32'h0,        1, 32'h8,     0, 32'h0,        32'h8);
    // Memory waits three cycles at PC=8.
    tbl[10] = mk(0, 1, 0, 32'h0,      0, 32'h0,        1, 32'h8,     0, 32'h0,        32'h8);
    tbl[11] = mk(0, 1, 0, 32'h0,      0, 32'h0,        1, 32'h8,     0, 32'h0,        32'h8);
    tbl[12] = mk(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h8,     0, 32'h0,        32'h8);
    tbl[13] = mk(0, 0, 0, 32'h0,      1, 32'h3333_0008,0, 32'h8,     1, 32'h3333_0008,32'h8);
    tbl[14] = mk(0, 1, 0, 32'h0,      0, 32'h0,        1, 32'h100,   0, 32'h0,        32'h100);
    tbl[15] = mk(0, 0, 0, 32'h0,      1, 32'h4444_0100,0, 32'h100,   1, 32'h4444_0100,32'h100);
    tbl[16] = mk(0, 1, 0, 32'h0,      0, 32'h0,        1, 32'h104,   0, 32'h0,        32'h104);

    for (int i = 0; i < c_NVEC; i++) begin
      cyc(tbl[i].rst, tbl[i].le, tbl[i].bt, tbl[i].ta, tbl[i].ack, tbl[i].rd);
      chk($sformatf("vec%0d imem_req", i),    {31'd0, imem_req},    {31'd0, tbl[i].e_req});
      chk($sformatf("vec%0d imem_addr", i),   imem_addr,            tbl[i].e_addr);
      chk($sformatf("vec%0d fetch_valid", i), {31'd0, fetch_valid}, {31'd0, tbl[i].e_vld});
      chk($sformatf("vec%0d instr", i),       instruction_out,      tbl[i].e_ins);
      chk($sformatf("vec%0d pc_out", i),      pc_out,               tbl[i].e_pc);
    end

    // ---- pending redirects: two branches during WAIT, newer one wins ----
    mcyc("pend0", 0, 0, 1, 32'h200, 0, 32'h0);
    mcyc("pend1", 0, 0, 1, 32'h301, 0, 32'h0);
    mcyc("pend2", 0, 1, 0, 32'h0,   1, 32'hAAAA_0104);
    mcyc("pend3", 0, 1, 0, 32'h0,   0, 32'h0);
    chk("pend delay slot addr", imem_addr, 32'h108);
    mcyc("pend4", 0, 0, 0, 32'h0,   1, 32'h5555_0108);
    mcyc("pend5", 0, 1, 0, 32'h0,   0, 32'h0);
    chk("pend target addr", imem_addr, 32'h300);
    mcyc("pend6", 0, 0, 0, 32'h0,   1, 32'h6666_0300);
    mcyc("pend7", 0, 1, 0, 32'h0,   0, 32'h0);
    chk("pend cleared addr", imem_addr, 32'h304);

    // ---- reset during WAIT at PC=0x40 with coincident ack/LE/branch ----
    mcyc("rw0", 1, 0, 0, 32'h0,  0, 32'h0);
    mcyc("rw1", 0, 0, 0, 32'h0,  1, 32'h7);
    mcyc("rw2", 0, 1, 1, 32'h40, 0, 32'h0);
    mcyc("rw3", 0, 0, 0, 32'h0,  1, 32'h8);
    mcyc("rw4", 0, 1, 0, 32'h0,  0, 32'h0);
    mcyc("rw5", 0, 0, 1, 32'h80, 0, 32'h0);
    chk("rw wait addr", imem_addr, 32'h40);
    mcyc("rw6", 1, 1, 1, 32'h123, 1, 32'hBEEF);
    chk("rw reset addr",  imem_addr,              c_RESET_PC);
    chk("rw reset req",   {31'd0, imem_req},      32'd1);
    chk("rw reset valid", {31'd0, fetch_valid},   32'd0);
    chk("rw reset instr", instruction_out,        c_NOP);
    mcyc("rw7", 0, 0, 0, 32'h0, 1, 32'h9);
    mcyc("rw8", 0, 1, 0, 32'h0, 0, 32'h0);
    mcyc("rw9", 0, 0, 0, 32'h0, 1, 32'hA);
    mcyc("rwA", 0, 1, 0, 32'h0, 0, 32'h0);
    chk("rw no stale redirect", imem_addr, 32'h8);

    // ---- wrap-around from 0xFFFF_FFFC to 0 ----
    mcyc("wr0", 0, 0, 0, 32'h0,         1, 32'hB);
    mcyc("wr1", 0, 1, 1, 32'hFFFF_FFFB, 0, 32'h0);
    mcyc("wr2", 0, 0, 0, 32'h0,         1, 32'hC);
    mcyc("wr3", 0, 1, 0, 32'h0,         0, 32'h0);
    chk("wrap addr F8", imem_addr, 32'hFFFF_FFF8);
    mcyc("wr4", 0, 0, 0, 32'h0,         1, 32'hD);
    mcyc("wr5", 0, 1, 0, 32'h0,         0, 32'h0);
    chk("wrap addr FC", imem_addr, 32'hFFFF_FFFC);
    mcyc("wr6", 0, 0, 0, 32'h0,         1, 32'hE);
    mcyc("wr7", 0, 1, 0, 32'h0,         0, 32'h0);
    chk("wrap addr 0", imem_addr, 32'h0);

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 1500; k++) begin
      mcyc($sformatf("rnd%0d", k),
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0),
           $urandom,
           ($urandom_range(0, 2) != 0),
           $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
